mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one 64-bit memory port between instruction fetch and load/store.
// Data has priority, fetch has a starvation guard, and at most one transaction is outstanding.
module mem_port_arbiter #(
    parameter int ADDR_W        = 64,
    parameter int MAX_D_STREAK  = 4,
    parameter bit INST_WORD_SEL = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req_valid,
    input  logic [ADDR_W-1:0] if_req_addr,
    output logic              if_req_ready,
    input  logic              if_flush,
    output logic              if_rsp_valid,
    output logic [31:0]       if_rsp_inst,
    input  logic              d_req_valid,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic              d_req_we,
    input  logic [63:0]       d_req_wdata,
    input  logic [7:0]        d_req_wmask,
    output logic              d_req_ready,
    output logic              d_rsp_valid,
    output logic [63:0]       d_rsp_rdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic              mem_req_we,
    output logic [63:0]       mem_req_wdata,
    output logic [7:0]        mem_req_wmask,
    input  logic              mem_rsp_valid,
    input  logic [63:0]       mem_rsp_rdata,
    output logic              busy
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;
    localparam int STREAK_W = $clog2(MAX_D_STREAK + 2);

    logic [0:0]          state_q;
    logic                owner_if_q;
    logic                drop_q;
    logic                addr2_q;
    logic [STREAK_W-1:0] streak_q;

    logic in_idle;
    logic in_wait;
    logic if_eff;
    logic streak_full;
    logic grant_if;
    logic grant_d;
    logic issue;
    logic rsp_take;

    function automatic logic [31:0] sel_inst(input logic [63:0] rdata, input logic hi_word);
        if (INST_WORD_SEL && hi_word)
            return rdata[63:32];
        else
            return rdata[31:0];
    endfunction

    // Outputs are forced low while reset is held, even on the input pass-through paths.
    assign in_idle     = rst_n && (state_q == S_IDLE);
    assign in_wait     = rst_n && (state_q == S_WAIT);
    assign if_eff      = if_req_valid & ~if_flush;
    assign streak_full = (streak_q == STREAK_W'(MAX_D_STREAK));

    assign grant_if = in_idle & if_eff & (~d_req_valid | streak_full);
    assign grant_d  = in_idle & d_req_valid & ~grant_if;

    assign mem_req_valid = grant_if | grant_d;
    assign issue         = mem_req_valid & mem_req_ready;
    assign if_req_ready  = issue & grant_if;
    assign d_req_ready   = issue & grant_d;

    always_comb begin
        mem_req_addr  = '0;
        mem_req_we    = 1'b0;
        mem_req_wdata = '0;
        mem_req_wmask = '0;
        if (grant_d) begin
            mem_req_addr  = d_req_addr;
            mem_req_we    = d_req_we;
            mem_req_wdata = d_req_wdata;
            mem_req_wmask = d_req_wmask;
        end else if (grant_if) begin
            mem_req_addr  = if_req_addr;
        end
    end

    // Response routing is same-cycle; a flushed fetch swallows its response pulse.
    assign rsp_take     = in_wait & mem_rsp_valid;
    assign d_rsp_valid  = rsp_take & ~owner_if_q;
    assign d_rsp_rdata  = d_rsp_valid ? mem_rsp_rdata : '0;
    assign if_rsp_valid = rsp_take & owner_if_q & ~drop_q & ~if_flush;
    assign if_rsp_inst  = if_rsp_valid ? sel_inst(mem_rsp_rdata, addr2_q) : '0;
    assign busy         = in_wait;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            owner_if_q <= 1'b0;
            drop_q     <= 1'b0;
            addr2_q    <= 1'b0;
            streak_q   <= '0;
        end else if (state_q == S_IDLE) begin
            if (issue) begin
                state_q    <= S_WAIT;
                owner_if_q <= grant_if;
                addr2_q    <= grant_if ? if_req_addr[2] : d_req_addr[2];
                drop_q     <= 1'b0;
            end
            // Streak counts data wins only while fetch is actually waiting.
            if (!if_eff)
                streak_q <= '0;
            else if (issue)
                streak_q <= (grant_d && !streak_full) ? streak_q + STREAK_W'(1) :
                            grant_d                   ? streak_q : '0;
        end else begin
            if (mem_rsp_valid) begin
                state_q <= S_IDLE;
                drop_q  <= 1'b0;
            end else if (owner_if_q && if_flush) begin
                drop_q  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: the bench plays the memory side and
// queues every expected response at issue time.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req_valid = 1'b0;
    logic [63:0] if_req_addr = '0;
    logic        if_req_ready;
    logic        if_flush = 1'b0;
    logic        if_rsp_valid;
    logic [31:0] if_rsp_inst;
    logic        d_req_valid = 1'b0;
    logic [63:0] d_req_addr = '0;
    logic        d_req_we = 1'b0;
    logic [63:0] d_req_wdata = '0;
    logic [7:0]  d_req_wmask = '0;
    logic        d_req_ready;
    logic        d_rsp_valid;
    logic [63:0] d_rsp_rdata;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [63:0] mem_req_addr;
    logic        mem_req_we;
    logic [63:0] mem_req_wdata;
    logic [7:0]  mem_req_wmask;
    logic        mem_rsp_valid = 1'b0;
    logic [63:0] mem_rsp_rdata = '0;
    logic        busy;

    typedef struct {
        logic        is_if;
        logic [63:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(64), .MAX_D_STREAK(4), .INST_WORD_SEL(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
        .if_flush(if_flush), .if_rsp_valid(if_rsp_valid), .if_rsp_inst(if_rsp_inst),
        .d_req_valid(d_req_valid), .d_req_addr(d_req_addr), .d_req_we(d_req_we),
        .d_req_wdata(d_req_wdata), .d_req_wmask(d_req_wmask), .d_req_ready(d_req_ready),
        .d_rsp_valid(d_rsp_valid), .d_rsp_rdata(d_rsp_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_req_we(mem_req_we), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata), .busy(busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push_exp(input logic is_if, input logic [63:0] data);
        exp_t e;
        e.is_if = is_if;
        e.data  = data;
        sb.push_back(e);
    endtask

    // Response monitor, sampled mid low phase.
    always @(negedge clk) begin
        exp_t e;
        #3;
        if (if_rsp_valid || d_rsp_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_rsp", 64'({if_rsp_valid, d_rsp_valid}), 64'd0);
            end else begin
                e = sb.pop_front();
                check("rsp_if_valid", 64'(if_rsp_valid), 64'(e.is_if));
                check("rsp_d_valid", 64'(d_rsp_valid), 64'(!e.is_if));
                check("rsp_data", e.is_if ? 64'(if_rsp_inst) : d_rsp_rdata, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        logic [63:0] rd;
        logic        exp_if;

        // Reset state
        tick();
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_mem_valid", 64'(mem_req_valid), 64'd0);
        check("rst_if_rsp", 64'(if_rsp_valid), 64'd0);
        check("rst_d_rsp", 64'(d_rsp_valid), 64'd0);
        check("rst_rdy", 64'({if_req_ready, d_req_ready}), 64'd0);
        tick();
        rst_n = 1'b1;

        // Fetch only
        tick();
        if_req_valid = 1'b1; if_req_addr = 64'h8000_0004; mem_req_ready = 1'b1;
        #1;
        check("f_addr", mem_req_addr, 64'h8000_0004);
        check("f_if_rdy", 64'(if_req_ready), 64'd1);
        check("f_we", 64'(mem_req_we), 64'd0);
        check("f_busy0", 64'(busy), 64'd0);
        push_exp(1'b1, 64'h0000_0013);
        tick();
        if_req_valid = 1'b0; mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1; mem_rsp_rdata = 64'h0000_0013_0010_0093;
        #1;
        check("f_busy1", 64'(busy), 64'd1);
        check("f_memv_wait", 64'(mem_req_valid), 64'd0);
        tick();
        mem_rsp_valid = 1'b0;
        #1;
        check("f_busy2", 64'(busy), 64'd0);

        // Simultaneous requests: data first, then fetch
        tick();
        if_req_valid = 1'b1; if_req_addr = 64'h1000;
        d_req_valid = 1'b1; d_req_addr = 64'h200; mem_req_ready = 1'b1;
        #1;
        check("sim_d_rdy", 64'(d_req_ready), 64'd1);
        check("sim_if_rdy", 64'(if_req_ready), 64'd0);
        check("sim_addr", mem_req_addr, 64'h200);
        push_exp(1'b0, 64'h1111_2222_3333_4444);
        tick();
        d_req_valid = 1'b0; mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1; mem_rsp_rdata = 64'h1111_2222_3333_4444;
        #1;
        check("sim_if_rdy_wait", 64'(if_req_ready), 64'd0);
        tick();
        mem_rsp_valid = 1'b0; mem_req_ready = 1'b1;
        #1;
        check("sim_if_rdy2", 64'(if_req_ready), 64'd1);
        check("sim_addr2", mem_req_addr, 64'h1000);
        push_exp(1'b1, 64'hCCCC_DDDD);
        tick();
        if_req_valid = 1'b0; mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1; mem_rsp_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
        tick();
        mem_rsp_valid = 1'b0;

        // Starvation guard, two rounds to show the streak restarts
        if_req_valid = 1'b1; if_req_addr = 64'h2004; d_req_valid = 1'b1;
        for (int r = 0; r < 2; r++) begin
            for (int g = 0; g < 5; g++) begin
                tick();
                mem_rsp_valid = 1'b0; mem_req_ready = 1'b1;
                d_req_addr = 64'h400 + 64'(g * 8);
                #1;
                exp_if = (g == 4);
                check("starve_if_rdy", 64'(if_req_ready), 64'(exp_if));
                check("starve_d_rdy", 64'(d_req_ready), 64'(!exp_if));
                rd = {32'hF000_0000 | 32'(r * 8 + g), 32'h0000_1000 | 32'(r * 8 + g)};
                push_exp(exp_if, exp_if ? {32'h0, rd[63:32]} : rd);
                tick();
                mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_rdata = rd;
            end
        end
        tick();
        mem_rsp_valid = 1'b0; if_req_valid = 1'b0; d_req_valid = 1'b0;

        // Flush in WAIT drops the fetch response
        tick();
        if_req_valid = 1'b1; if_req_addr = 64'h3000; mem_req_ready = 1'b1;
        #1;
        check("fl_issue", 64'(if_req_ready), 64'd1);
        tick();
        if_req_valid = 1'b0; mem_req_ready = 1'b0; if_flush = 1'b1;
        #1;
        check("fl_busy", 64'(busy), 64'd1);
        tick();
        if_flush = 1'b0;
        tick();
        tick();
        mem_rsp_valid = 1'b1; mem_rsp_rdata = 64'h1234_5678_9ABC_DEF0;
        #1;
        check("fl_drop", 64'(if_rsp_valid), 64'd0);
        tick();
        mem_rsp_valid = 1'b0;
        #1;
        check("fl_idle", 64'(busy), 64'd0);
        tick();
        if_req_valid = 1'b1; if_req_addr = 64'h3004; mem_req_ready = 1'b1;
        #1;
        check("fl_next_rdy", 64'(if_req_ready), 64'd1);
        push_exp(1'b1, 64'h9999_0001);
        tick();
        if_req_valid = 1'b0; mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1; mem_rsp_rdata = 64'h9999_0001_8888_0002;
        tick();
        mem_rsp_valid = 1'b0;

        // Flush in IDLE masks the fetch request
        tick();
        if_req_valid = 1'b1; if_flush = 1'b1; mem_req_ready = 1'b1;
        #1;
        check("fl_idle_memv", 64'(mem_req_valid), 64'd0);
        check("fl_idle_rdy", 64'(if_req_ready), 64'd0);
        tick();
        if_req_valid = 1'b0; if_flush = 1'b0; mem_req_ready = 1'b0;

        // Flush does not touch a data transaction
        tick();
        d_req_valid = 1'b1; d_req_addr = 64'h500; mem_req_ready = 1'b1;
        #1;
        check("dfl_rdy", 64'(d_req_ready), 64'd1);
        push_exp(1'b0, 64'h0BAD_F00D_0000_0001);
        tick();
        d_req_valid = 1'b0; mem_req_ready = 1'b0; if_flush = 1'b1;
        mem_rsp_valid = 1'b1; mem_rsp_rdata = 64'h0BAD_F00D_0000_0001;
        #1;
        check("dfl_rsp", 64'(d_rsp_valid), 64'd1);
        tick();
        if_flush = 1'b0; mem_rsp_valid = 1'b0;

        // Store with back-pressure
        tick();
        d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = 64'h600;
        d_req_wdata = 64'hDEAD_BEEF; d_req_wmask = 8'h0F; mem_req_ready = 1'b0;
        #1;
        check("st_rdy0", 64'(d_req_ready), 64'd0);
        check("st_memv", 64'(mem_req_valid), 64'd1);
        check("st_wmask", 64'(mem_req_wmask), 64'h0F);
        check("st_we", 64'(mem_req_we), 64'd1);
        tick();
        #1;
        check("st_rdy1", 64'(d_req_ready), 64'd0);
        tick();
        mem_req_ready = 1'b1;
        #1;
        check("st_rdy2", 64'(d_req_ready), 64'd1);
        check("st_wdata", mem_req_wdata, 64'hDEAD_BEEF);
        push_exp(1'b0, 64'h77);
        tick();
        d_req_valid = 1'b0; d_req_we = 1'b0; d_req_wmask = 8'h00; mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1; mem_rsp_rdata = 64'h77;
        tick();
        mem_rsp_valid = 1'b0;

        // Response while IDLE is ignored
        tick();
        mem_rsp_valid = 1'b1; mem_rsp_rdata = 64'h5555;
        #1;
        check("stray_if", 64'(if_rsp_valid), 64'd0);
        check("stray_d", 64'(d_rsp_valid), 64'd0);
        check("stray_busy", 64'(busy), 64'd0);
        tick();
        mem_rsp_valid = 1'b0;

        // Async reset in WAIT
        tick();
        if_req_valid = 1'b1; if_req_addr = 64'h4000; mem_req_ready = 1'b1;
        #1;
        check("ar_issue", 64'(if_req_ready), 64'd1);
        tick();
        if_req_valid = 1'b0; mem_req_ready = 1'b0;
        #1;
        check("ar_busy_pre", 64'(busy), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("ar_busy", 64'(busy), 64'd0);
        check("ar_memv", 64'(mem_req_valid), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        mem_rsp_valid = 1'b1; mem_rsp_rdata = 64'hABCD_0000_ABCD_0000;
        #1;
        check("ar_late_if", 64'(if_rsp_valid), 64'd0);
        check("ar_late_busy", 64'(busy), 64'd0);
        tick();
        mem_rsp_valid = 1'b0;

        tick();
        tick();
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
